// File: rtl/gfx_arb_pkg.sv
// gfx_arb_pkg: shared requester indices, state encoding and default sizes for the frame-buffer write arbiter
package gfx_arb_pkg;
  localparam int NUM_REQ = 3;
  typedef logic [1:0] req_idx_t;
  localparam req_idx_t REQ_FILL = 2'd0;
  localparam req_idx_t REQ_LINE = 2'd1;
  localparam req_idx_t REQ_BYP  = 2'd2;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
  localparam int DEF_ADDR_W    = 28;
  localparam int DEF_DATA_W    = 128;
  localparam int DEF_MASK_W    = DEF_DATA_W / 8;
  localparam int DEF_BURST_LEN = 2;
endpackage

// File: rtl/gfx_rr_picker.sv
// gfx_rr_picker: combinational round-robin winner select starting at rr_ptr,
// with an optional absolute-priority mode for the bypass requester.
module gfx_rr_picker import gfx_arb_pkg::*; (
  input  logic [NUM_REQ-1:0] valid,
  input  req_idx_t           rr_ptr,
  input  logic               byp_prio,
  output logic [NUM_REQ-1:0] winner
);
  logic [NUM_REQ-1:0] cand;
  always_comb begin
    cand = valid;
    cand[REQ_BYP] = valid[REQ_BYP] & ~byp_prio;
    winner = '0;
    // walk from lowest to highest priority so the requester at rr_ptr overwrites last
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (cand[(int'(rr_ptr) + k) % NUM_REQ]) winner = NUM_REQ'(1) << ((int'(rr_ptr) + k) % NUM_REQ);
    if (byp_prio && valid[REQ_BYP]) winner = NUM_REQ'(1) << REQ_BYP;
  end
endmodule

// File: rtl/gfx_mem_arbiter.sv
// gfx_mem_arbiter: grants whole write bursts to fill / line / CPU-bypass sources, round-robin.
// Define GFX_ARB_BYPASS_PRIO_EN to give bypass writes absolute priority over fill and line.
module gfx_mem_arbiter import gfx_arb_pkg::*; #(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MASK_W    = DEF_MASK_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic [MASK_W-1:0] fill_mask,
  input  logic              line_valid,
  output logic              line_ready,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic [DATA_W-1:0] line_data,
  input  logic [MASK_W-1:0] line_mask,
  input  logic              byp_valid,
  output logic              byp_ready,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [DATA_W-1:0] byp_data,
  input  logic [MASK_W-1:0] byp_mask,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [MASK_W-1:0] mem_mask,
  output logic              mem_first,
  output logic              mem_last,
  output logic [2:0]        grant,
  output logic              busy
);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  arb_state_t state, state_d;
  logic [NUM_REQ-1:0] req, winner, grant_d;
  logic [CNT_W-1:0] beat_cnt, cnt_d;
  req_idx_t rr_ptr, ptr_d, ptr_next;
  logic hs;
`ifdef GFX_ARB_BYPASS_PRIO_EN
  localparam logic BYP_PRIO = 1'b1;
  assign ptr_next = grant[REQ_FILL] ? REQ_LINE : grant[REQ_LINE] ? REQ_FILL : rr_ptr;
`else
  localparam logic BYP_PRIO = 1'b0;
  assign ptr_next = grant[REQ_FILL] ? REQ_LINE : grant[REQ_LINE] ? REQ_BYP : REQ_FILL;
`endif
  assign req = {byp_valid, line_valid, fill_valid};
  gfx_rr_picker u_picker (
    .valid    (req),
    .rr_ptr   (rr_ptr),
    .byp_prio (BYP_PRIO),
    .winner   (winner)
  );
  // outputs decode only registered state, so an asserted reset silences them at once
  assign busy      = state == ARB_BURST;
  assign mem_valid = busy & |(grant & req);
  assign {byp_ready, line_ready, fill_ready} = grant & {NUM_REQ{busy & mem_ready}};
  assign mem_addr  = grant[REQ_FILL] ? fill_addr : grant[REQ_LINE] ? line_addr : byp_addr;
  assign mem_data  = grant[REQ_FILL] ? fill_data : grant[REQ_LINE] ? line_data : byp_data;
  assign mem_mask  = grant[REQ_FILL] ? fill_mask : grant[REQ_LINE] ? line_mask : byp_mask;
  assign mem_first = busy & (beat_cnt == '0);
  assign mem_last  = busy & (beat_cnt == CNT_W'(BURST_LEN - 1));
  assign hs        = mem_valid & mem_ready;
  always_comb begin
    state_d = state;
    grant_d = grant;
    cnt_d   = beat_cnt;
    ptr_d   = rr_ptr;
    if (state == ARB_IDLE) begin
      if (|req) begin
        state_d = ARB_BURST;
        grant_d = winner;
        cnt_d   = '0;
      end
    end else if (hs) begin
      if (mem_last) begin
        state_d = ARB_IDLE;
        grant_d = '0;
        ptr_d   = ptr_next;
      end else cnt_d = beat_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      beat_cnt <= '0;
      rr_ptr   <= REQ_FILL;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      beat_cnt <= cnt_d;
      rr_ptr   <= ptr_d;
    end
  end
endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// tb_gfx_mem_arbiter: scoreboard bench; expected beats are queued with the stimulus, observed beats are captured on handshakes.
module tb_gfx_mem_arbiter;
  import gfx_arb_pkg::*;
  localparam int AW = 28, DW = 128, MW = 16, BL = 2;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    logic          first;
    logic          last;
    logic [2:0]    grant;
  } beat_t;
  logic clk = 1'b0, rst = 1'b0;
  logic fill_valid, line_valid, byp_valid, fill_ready, line_ready, byp_ready;
  logic [AW-1:0] fill_addr, line_addr, byp_addr, mem_addr;
  logic [DW-1:0] fill_data, line_data, byp_data, mem_data;
  logic [MW-1:0] fill_mask, line_mask, byp_mask, mem_mask;
  logic mem_valid, mem_ready, mem_first, mem_last, busy;
  logic [2:0] grant;
  logic [AW-1:0] addr_c [3];
  logic [DW-1:0] data_c [3];
  logic [MW-1:0] mask_c [3];
  beat_t exp_q[$], obs_q[$];
  int obs_cyc[$];
  int cyc = 0, n_vec = 0, n_err = 0;

  gfx_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr), .fill_data(fill_data), .fill_mask(fill_mask),
    .line_valid(line_valid), .line_ready(line_ready), .line_addr(line_addr), .line_data(line_data), .line_mask(line_mask),
    .byp_valid(byp_valid), .byp_ready(byp_ready), .byp_addr(byp_addr), .byp_data(byp_data), .byp_mask(byp_mask),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_mask(mem_mask),
    .mem_first(mem_first), .mem_last(mem_last), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst && mem_valid && mem_ready) begin
      obs_q.push_back({mem_addr, mem_data, mem_mask, mem_first, mem_last, grant});
      obs_cyc.push_back(cyc);
    end

  task automatic push_beats(int r, int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back({addr_c[r], data_c[r], mask_c[r], k == 0, k == BL - 1, 3'(1 << r)});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fill_valid = 1'b0; line_valid = 1'b0; byp_valid = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic wait_lasts(int n, output bit to);
    int c, t;
    c = 0; t = 0;
    while (c < n && t < 200) begin
      @(negedge clk);
      t++;
      if (mem_valid && mem_ready && mem_last) c++;
    end
    to = c < n;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_vec++; if ({mem_valid, grant, busy} !== 5'b0) begin n_err++; $display("FAIL reset_out: got valid/grant/busy %b want 00000", {mem_valid, grant, busy}); end
    n_vec++; if ({fill_ready, line_ready, byp_ready, mem_first} !== 4'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", {fill_ready, line_ready, byp_ready, mem_first}); end
    fill_valid = 1'b1; line_valid = 1'b1; byp_valid = 1'b1; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if ({mem_valid, grant, busy} !== 5'b0) begin n_err++; $display("FAIL reset_hold: got %b want 00000", {mem_valid, grant, busy}); end
  endtask

  task automatic test_single();
    bit to;
    int gap;
    do_reset();
    fill_valid = 1'b1; mem_ready = 1'b1;
    push_beats(REQ_FILL, BL); push_beats(REQ_FILL, BL);
    @(posedge clk); @(negedge clk);
    n_vec++; if ({grant, busy} !== 4'b0011) begin n_err++; $display("FAIL single_latency: got grant/busy %b want 0011", {grant, busy}); end
    wait_lasts(2, to);
    fill_valid = 1'b0;
    n_vec++; if (to) begin n_err++; $display("FAIL single_timeout: got <2 bursts want 2"); end
    repeat (2) @(posedge clk);
    gap = obs_cyc.size() >= 3 ? obs_cyc[2] - obs_cyc[1] : -1;
    n_vec++; if (gap !== 2) begin n_err++; $display("FAIL single_bubble: got gap %0d want 2", gap); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL single_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_round_robin();
    bit to;
    int ptr;
    do_reset();
    fill_valid = 1'b1; line_valid = 1'b1; byp_valid = 1'b1; mem_ready = 1'b1;
    ptr = 0;
    for (int b = 0; b < 6; b++) begin
`ifdef GFX_ARB_BYPASS_PRIO_EN
      push_beats(REQ_BYP, BL);
`else
      push_beats(ptr, BL);
      ptr = (ptr + 1) % 3;
`endif
    end
    wait_lasts(6, to);
    fill_valid = 1'b0; line_valid = 1'b0; byp_valid = 1'b0;
    n_vec++; if (to) begin n_err++; $display("FAIL rr_timeout: got <6 bursts want 6"); end
    repeat (2) @(posedge clk);
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rr_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] pat;
    pat = 5'b10010;
    do_reset();
    line_valid = 1'b1;
    push_beats(REQ_LINE, BL);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      mem_ready = pat[i];
      @(negedge clk);
      n_vec++; if (line_ready !== pat[i]) begin n_err++; $display("FAIL bp_ready%0d: got %b want %b", i, line_ready, pat[i]); end
      n_vec++; if (mem_data !== line_data) begin n_err++; $display("FAIL bp_data%0d: got %h want %h", i, mem_data, line_data); end
      n_vec++; if (grant !== 3'b010) begin n_err++; $display("FAIL bp_grant%0d: got %b want 010", i, grant); end
      @(posedge clk);
      #1;
    end
    line_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_done: got busy %b want 0", busy); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_owner_stall();
    do_reset();
    byp_valid = 1'b1; mem_ready = 1'b1;
    push_beats(REQ_BYP, BL);
    @(posedge clk);
    @(posedge clk);
    #1;
    byp_valid = 1'b0; fill_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if ({grant, fill_ready, mem_valid, busy} !== 6'b100001) begin n_err++; $display("FAIL stall%0d: got grant/fready/mvalid/busy %b want 100001", i, {grant, fill_ready, mem_valid, busy}); end
      @(posedge clk);
      #1;
    end
    byp_valid = 1'b1;
    @(posedge clk);
    #1;
    byp_valid = 1'b0; fill_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stall_done: got busy %b want 0", busy); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL stall_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    do_reset();
    fill_valid = 1'b1; line_valid = 1'b1; mem_ready = 1'b1;
    push_beats(REQ_FILL, BL); push_beats(REQ_LINE, 1);
    wait_lasts(1, to);
    n_vec++; if (to) begin n_err++; $display("FAIL rmid_timeout: got no fill burst want 1"); end
    @(posedge clk);
    @(posedge clk);
    #1;
    n_vec++; if ({grant, mem_first, mem_last} !== 5'b01001) begin n_err++; $display("FAIL rmid_beat1: got grant/first/last %b want 01001", {grant, mem_first, mem_last}); end
    rst = 1'b0;
    #1;
    n_vec++; if ({mem_valid, grant, busy, line_ready} !== 6'b0) begin n_err++; $display("FAIL rmid_async: got %b want 000000", {mem_valid, grant, busy, line_ready}); end
    @(posedge clk);
    #1;
    rst = 1'b1; mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (grant !== 3'b001) begin n_err++; $display("FAIL rmid_regrant: got %b want 001", grant); end
    fill_valid = 1'b0; line_valid = 1'b0;
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rmid_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rmid_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    addr_c[0] = 28'h0000100; data_c[0] = 128'h0F0F_1111_2222_3333_4444_5555_6666_7777; mask_c[0] = 16'h0000;
    addr_c[1] = 28'h0000A40; data_c[1] = 128'hA5A5_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE; mask_c[1] = 16'h00FF;
    addr_c[2] = 28'hFFFFFC0; data_c[2] = 128'hC3C3_0123_4567_89AB_CDEF_FEDC_BA98_7654; mask_c[2] = 16'hF00F;
    fill_addr = addr_c[0]; fill_data = data_c[0]; fill_mask = mask_c[0];
    line_addr = addr_c[1]; line_data = data_c[1]; line_mask = mask_c[1];
    byp_addr = addr_c[2]; byp_data = data_c[2]; byp_mask = mask_c[2];
    fill_valid = 1'b0; line_valid = 1'b0; byp_valid = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_owner_stall();
    test_reset_mid();
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
